fetch_ctrl: RTL

Instruction-fetch sequencer that drives the 8-bit byte address of the combinational 32-bit instruction memory. It captures each returned word into a 2-entry prefetch buffer and hands instructions to decode over a valid/ready handshake. It handles start, PC redirect (branch/jump) with buffer flush, and halt on a sentinel instruction word. It sits between the PC/branch logic and the decode stage of the processor.

---
 rtl/fetch_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with a 2-entry prefetch buffer.
// Drives the byte address of a zero-latency instruction memory and captures
// each returned word with its address. Instructions go to decode over a
// valid/ready handshake. The block supports start, redirect with a buffer
// flush, and halt on a sentinel instruction word.
module fetch_ctrl #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        startIn,
    output logic [7:0]  pcOut,
    input  logic [31:0] insIn,
    input  logic        redirectIn,
    input  logic [7:0]  redirectPcIn,
    output logic [31:0] insOut,
    output logic [7:0]  insPcOut,
    output logic        validOut,
    input  logic        readyIn,
    output logic        haltedOut,
    output logic        busyOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } stateT;

    localparam logic [1:0] FULL = 2'd2;

    stateT       state;
    stateT       stateNext;
    logic [7:0]  pcReg;
    logic [7:0]  pcNext;
    logic [1:0]  countReg;
    logic [1:0]  countNext;
    logic        busyReg;
    logic        haltedReg;

    // Buffer slots; slot 0 is always the head presented to decode.
    logic [31:0] bufIns [DEPTH];
    logic [7:0]  bufPc  [DEPTH];

    logic        flush;
    logic        pop;
    logic        canPush;
    logic        push;
    logic        haltHit;
    logic        wrIdx;

    // Handshake and buffer-control decode for the current cycle.
    always_comb begin
        // A redirect outranks everything; IDLE ignores it.
        flush   = redirectIn && (state != IDLE);
        // A pop coinciding with a redirect is discarded, so it is masked here.
        pop     = (countReg != 2'd0) && readyIn && !flush;
        canPush = (state == FETCH) && ((countReg < FULL) || pop);
        push    = !flush && canPush && (insIn != HALT_WORD);
        haltHit = !flush && canPush && (insIn == HALT_WORD);
        // Slot that receives the new word once any pop has shifted the buffer.
        wrIdx   = ((countReg == 2'd1) && !pop) || (countReg == FULL);
    end

    // Next-state, next-PC and next-occupancy computation.
    always_comb begin
        stateNext = state;
        pcNext    = pcReg;
        countNext = countReg + {1'b0, push} - {1'b0, pop};
        case (state)
            IDLE: begin
                if (startIn) begin
                    stateNext = FETCH;
                    pcNext    = RESET_PC;
                end
            end
            FETCH: begin
                if (push) begin
                    pcNext = pcReg + 8'd4;
                end else if (haltHit) begin
                    stateNext = HALT;
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (flush) begin
            stateNext = FETCH;
            pcNext    = redirectPcIn & 8'hFC;
            countNext = 2'd0;
        end
    end

    // Sequencer state, fetch address and registered status outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            pcReg     <= RESET_PC;
            busyReg   <= 1'b0;
            haltedReg <= 1'b0;
        end else begin
            state     <= stateNext;
            pcReg     <= pcNext;
            busyReg   <= (stateNext == FETCH);
            haltedReg <= (stateNext == HALT);
        end
    end

    // Buffer occupancy counter.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            countReg <= 2'd0;
        end else begin
            countReg <= countNext;
        end
    end

    // Per-slot storage: load the fetched word, or shift toward the head on a pop.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
        if (gi < DEPTH - 1) begin : gShift
            // Slot with a successor: shifts forward when the head is consumed.
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    bufIns[gi] <= 32'h0;
                    bufPc[gi]  <= 8'h0;
                end else if (push && (wrIdx == 1'(gi))) begin
                    bufIns[gi] <= insIn;
                    bufPc[gi]  <= pcReg;
                end else if (pop) begin
                    bufIns[gi] <= bufIns[gi+1];
                    bufPc[gi]  <= bufPc[gi+1];
                end
            end
        end else begin : gTail
            // Last slot: only ever loaded from memory.
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    bufIns[gi] <= 32'h0;
                    bufPc[gi]  <= 8'h0;
                end else if (push && (wrIdx == 1'(gi))) begin
                    bufIns[gi] <= insIn;
                    bufPc[gi]  <= pcReg;
                end
            end
        end
    end

    assign pcOut     = pcReg;
    assign insOut    = bufIns[0];
    assign insPcOut  = bufPc[0];
    assign validOut  = (countReg != 2'd0);
    assign busyOut   = busyReg;
    assign haltedOut = haltedReg;

endmodule
